// File: rtl/seq_pkg.sv
// Shared types for the serial pattern transmitter and the sequence detectors it feeds.
package seq_pkg;

  localparam int unsigned SEQ_PAT_W = 4;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PAT_DEFAULT = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } tx_state_t;

  // Moore 1011 detector states, shared with the detector blocks.
  typedef enum logic [2:0] {
    DET_S0    = 3'd0,
    DET_S1    = 3'd1,
    DET_S10   = 3'd2,
    DET_S101  = 3'd3,
    DET_S1011 = 3'd4
  } det_state_t;

endpackage

// File: rtl/pattern_shifter.sv
// Rotating pattern register: next_bit_c is the bit to emit next, last_bit_c marks
// that the bit most recently emitted was the pattern's LSB.
module pattern_shifter
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] load_pat,
  output logic             next_bit_c,
  output logic             last_bit_c
);

  localparam int unsigned IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx_q;

  // A full rotation restores the pattern, so back-to-back repeats need no reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      pat_q <= {load_pat[PAT_W-2:0], load_pat[PAT_W-1]};
      idx_q <= IDX_TOP;
    end else if (shift) begin
      pat_q <= {pat_q[PAT_W-2:0], pat_q[PAT_W-1]};
      idx_q <= (idx_q == '0) ? IDX_TOP : idx_q - IDX_W'(1);
    end
  end

  assign next_bit_c = load ? load_pat[PAT_W-1] : pat_q[PAT_W-1];
  assign last_bit_c = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated
// rpt_cnt times with gap_len idle cycles between repetitions.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(SEQ_PAT_DEFAULT),
  parameter int unsigned      RPT_W       = 8,
  parameter int unsigned      GAP_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_pat_sel,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [RPT_W-1:0] rpt_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             hold,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  tx_state_t        state_q, state_d;
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_dec;
  logic [GAP_W-1:0] gap_q, gap_d, gap_len_q, gap_len_d;
  logic             out_d, valid_d, busy_d, done_d;
  logic             load, emit;
  logic             next_bit_c, last_bit_c;
  logic [PAT_W-1:0] load_pat;

  assign load_pat = start_pat_sel ? pattern_in : PAT_DEFAULT;

  pattern_shifter #(
    .PAT_W(PAT_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .shift      (emit),
    .load_pat   (load_pat),
    .next_bit_c (next_bit_c),
    .last_bit_c (last_bit_c)
  );

  // State and outputs describe the current cycle; each edge registers the next slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rpt_q     <= '0;
      gap_q     <= '0;
      gap_len_q <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_q     <= rpt_d;
      gap_q     <= gap_d;
      gap_len_q <= gap_len_d;
      out       <= out_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rpt_d     = rpt_q;
    gap_d     = gap_q;
    gap_len_d = gap_len_q;
    out_d     = out;
    valid_d   = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
    load      = 1'b0;
    emit      = 1'b0;
    rpt_dec   = (rpt_q != '0) ? rpt_q - RPT_W'(1) : rpt_q;

    case (state_q)
      IDLE: begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          load      = 1'b1;
          emit      = 1'b1;
          busy_d    = 1'b1;
          state_d   = SEND;
          rpt_d     = (rpt_cnt == '0) ? RPT_W'(1) : rpt_cnt;
          gap_len_d = gap_len;
          gap_d     = '0;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
          out_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (!hold) begin
          if (!last_bit_c) begin
            emit = 1'b1;
          end else begin
            rpt_d = rpt_dec;
            if (rpt_dec == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
              out_d   = 1'b0;
            end else if (gap_len_q == '0) begin
              emit = 1'b1;
            end else begin
              state_d = GAP;
              gap_d   = gap_len_q;
              out_d   = 1'b0;
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          out_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (!hold) begin
          if (gap_q <= GAP_W'(1)) begin
            state_d = SEND;
            emit    = 1'b1;
          end
          if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (emit) begin
      out_d   = next_bit_c;
      valid_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: slot-queue model checked every cycle plus literal stream checks.
module tb_seq_pattern_tx;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned RPT_W = 8;
  localparam int unsigned GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             start_pat_sel = 1'b0;
  logic [PAT_W-1:0] pattern_in = '0;
  logic [RPT_W-1:0] rpt_cnt = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic             hold = 1'b0;
  logic             abort = 1'b0;
  logic             out, out_valid, busy, done;

  seq_pattern_tx #(
    .PAT_W       (PAT_W),
    .PAT_DEFAULT (4'b1011),
    .RPT_W       (RPT_W),
    .GAP_W       (GAP_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_pat_sel (start_pat_sel),
    .pattern_in    (pattern_in),
    .rpt_cnt       (rpt_cnt),
    .gap_len       (gap_len),
    .hold          (hold),
    .abort         (abort),
    .out           (out),
    .out_valid     (out_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start expands into a queue of output slots; hold stalls, abort flushes.
  typedef struct packed {
    logic o;
    logic v;
    logic d;
  } slot_t;

  slot_t m_q[$];
  logic  m_out = 1'b0, m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_active = 1'b0;

  always @(posedge clk) begin : model
    slot_t            s;
    logic [PAT_W-1:0] p;
    int               reps;
    if (rst) begin
      m_q.delete();
      m_out <= 1'b0; m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_active <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        p    = start_pat_sel ? pattern_in : 4'b1011;
        reps = (rpt_cnt == '0) ? 1 : int'(rpt_cnt);
        for (int r = 0; r < reps; r++) begin
          for (int b = int'(PAT_W) - 1; b >= 0; b--) begin
            s.o = p[b]; s.v = 1'b1; s.d = 1'b0;
            m_q.push_back(s);
          end
          if (r < reps - 1) begin
            for (int g = 0; g < int'(gap_len); g++) begin
              s = '0;
              m_q.push_back(s);
            end
          end
        end
        s = '0; s.d = 1'b1;
        m_q.push_back(s);
        s = m_q.pop_front();
        m_out <= s.o; m_valid <= s.v; m_done <= s.d;
        m_busy <= 1'b1; m_active <= 1'b1;
      end
    end else if (abort || m_done) begin
      m_q.delete();
      m_out <= 1'b0; m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_active <= 1'b0;
    end else if (hold) begin
      m_valid <= 1'b0;
    end else begin
      if (m_q.size() > 0) s = m_q.pop_front();
      else s = '0;
      m_out <= s.o; m_valid <= s.v; m_done <= s.d;
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out", 32'(out), 32'(m_out));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
    end
  end

  int          cyc, cap_n, mcap_n, done_at, det;
  logic [31:0] cap_bits, mcap_bits;
  logic [3:0]  sh;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (out_valid === 1'b1) begin
      cap_bits = {cap_bits[30:0], out};
      cap_n++;
      sh = {sh[2:0], out};
      if (cap_n >= 4 && sh == 4'b1011) det++;
    end
    if (m_valid) begin
      mcap_bits = {mcap_bits[30:0], m_out};
      mcap_n++;
    end
    if (done === 1'b1) done_at = cyc;
  endtask

  task automatic launch(input logic sel, input logic [PAT_W-1:0] pat,
                        input logic [RPT_W-1:0] rpt, input logic [GAP_W-1:0] gap);
    start_pat_sel = sel; pattern_in = pat; rpt_cnt = rpt; gap_len = gap; start = 1'b1;
    cyc = 0; cap_n = 0; mcap_n = 0; cap_bits = '0; mcap_bits = '0;
    done_at = -1; det = 0; sh = '0;
  endtask

  // Runs until the transmitter is idle again; stimulus keyed to the cycle count.
  task automatic run(input int hold_on, input int hold_off, input int abort_at,
                     input int rst_at, input int spulse, input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      start = (cyc == spulse);
      if (cyc == spulse) begin
        start_pat_sel = 1'b1; pattern_in = 4'b0000; rpt_cnt = 8'd5; gap_len = 4'd7;
      end
      hold  = (cyc >= hold_on && cyc < hold_off);
      abort = (cyc == abort_at);
      rst   = (cyc == rst_at);
      if (busy === 1'b0 && !m_active) return;
    end
    chk("run_timeout", 32'(1), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_out", 32'(out), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    tick();

    // Single default pattern
    launch(1'b0, 4'h0, 8'd1, 4'd0);
    run(-1, -1, -1, -1, -1, 40);
    chk("t1_bits", 32'(cap_bits[3:0]), 32'(4'b1011));
    chk("t1_model_bits", 32'(mcap_bits[3:0]), 32'(4'b1011));
    chk("t1_nbits", 32'(cap_n), 32'(4));
    chk("t1_done_at", 32'(done_at), 32'(5));
    chk("t1_idle_at", 32'(cyc), 32'(6));

    // Three back-to-back repetitions
    launch(1'b0, 4'h0, 8'd3, 4'd0);
    run(-1, -1, -1, -1, -1, 60);
    chk("t2_bits", 32'(cap_bits[11:0]), 32'(12'b101110111011));
    chk("t2_model_bits", 32'(mcap_bits[11:0]), 32'(12'b101110111011));
    chk("t2_detect", 32'(det), 32'(3));
    chk("t2_done_at", 32'(done_at), 32'(13));

    // Runtime pattern with gap
    launch(1'b1, 4'b0110, 8'd2, 4'd2);
    run(-1, -1, -1, -1, -1, 60);
    chk("t3_bits", 32'(cap_bits[7:0]), 32'(8'b01100110));
    chk("t3_model_bits", 32'(mcap_bits[7:0]), 32'(8'b01100110));
    chk("t3_nbits", 32'(cap_n), 32'(8));
    chk("t3_done_at", 32'(done_at), 32'(11));

    // Hold for three cycles after the second bit
    launch(1'b0, 4'h0, 8'd1, 4'd0);
    run(2, 5, -1, -1, -1, 40);
    chk("t4_bits", 32'(cap_bits[3:0]), 32'(4'b1011));
    chk("t4_nbits", 32'(cap_n), 32'(4));
    chk("t4_done_at", 32'(done_at), 32'(8));

    // Abort on the sixth bit, then restart at once
    launch(1'b0, 4'h0, 8'd4, 4'd0);
    run(-1, -1, 6, -1, -1, 60);
    chk("t5_bits", 32'(cap_bits[5:0]), 32'(6'b101110));
    chk("t5_nbits", 32'(cap_n), 32'(6));
    chk("t5_no_done", 32'(done_at), 32'(-1));
    chk("t5_idle_at", 32'(cyc), 32'(7));
    launch(1'b0, 4'h0, 8'd1, 4'd0);
    run(-1, -1, -1, -1, -1, 40);
    chk("t5_restart_bits", 32'(cap_bits[3:0]), 32'(4'b1011));
    chk("t5_restart_done_at", 32'(done_at), 32'(5));

    // Reset pulse in the first gap cycle
    launch(1'b0, 4'h0, 8'd2, 4'd3);
    run(-1, -1, -1, 5, -1, 60);
    chk("t6_rst_idle_at", 32'(cyc), 32'(6));
    chk("t6_rst_out_valid", 32'(out_valid), 32'(0));
    chk("t6_rst_nbits", 32'(cap_n), 32'(4));
    chk("t6_rst_no_done", 32'(done_at), 32'(-1));

    // rpt_cnt of zero sends one repetition
    launch(1'b0, 4'h0, 8'd0, 4'd0);
    run(-1, -1, -1, -1, -1, 40);
    chk("t6_rpt0_nbits", 32'(cap_n), 32'(4));
    chk("t6_rpt0_done_at", 32'(done_at), 32'(5));

    // start pulsed while sending is ignored
    launch(1'b0, 4'h0, 8'd2, 4'd0);
    run(-1, -1, -1, -1, 3, 60);
    chk("t6_busy_start_bits", 32'(cap_bits[7:0]), 32'(8'b10111011));
    chk("t6_busy_start_nbits", 32'(cap_n), 32'(8));
    chk("t6_busy_start_done_at", 32'(done_at), 32'(9));

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
